// File: rtl/fsm_input_arbiter.sv
// Round-robin arbiter that feeds one of three symbol streams into a downstream symbol FSM.
// Optional burst timeout is enabled by defining FSM_ARB_TIMEOUT_EN.
module fsm_input_arbiter #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] req_valid,
    input  logic [5:0] req_sym,
    input  logic [2:0] req_last,
    output logic [2:0] req_ready,
    output logic       sym_valid,
    output logic [1:0] sym,
    output logic       fsm_restart,
    output logic [1:0] grant_id,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [1:0] rr_ptr, rr_next, grant_next;
    logic [1:0] cand0, cand1, cand2, pick;
    logic       found;
    logic       own_valid, own_last, transfer, limit;
    logic [1:0] own_sym;

    function automatic logic [1:0] next_id(input logic [1:0] id);
        return (id == 2'd2) ? 2'd0 : id + 2'd1;
    endfunction

    function automatic logic bit_of(input logic [2:0] vec, input logic [1:0] id);
        case (id)
            2'd1:    return vec[1];
            2'd2:    return vec[2];
            default: return vec[0];
        endcase
    endfunction

    // Search order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); first valid requester wins.
    always_comb begin
        cand0 = rr_ptr;
        cand1 = next_id(cand0);
        cand2 = next_id(cand1);
        found = 1'b1;
        pick  = cand0;
        if (bit_of(req_valid, cand0)) begin
            pick = cand0;
        end else if (bit_of(req_valid, cand1)) begin
            pick = cand1;
        end else if (bit_of(req_valid, cand2)) begin
            pick = cand2;
        end else begin
            found = 1'b0;
        end
    end

    always_comb begin
        own_valid = bit_of(req_valid, grant_id);
        own_last  = bit_of(req_last, grant_id);
        case (grant_id)
            2'd1:    own_sym = req_sym[3:2];
            2'd2:    own_sym = req_sym[5:4];
            default: own_sym = req_sym[1:0];
        endcase
    end

    assign transfer  = (state == BURST) && own_valid;
    assign req_ready = (state == BURST) ? (3'b001 << grant_id) : 3'b000;
    assign busy      = (state == START) || (state == BURST);

`ifdef FSM_ARB_TIMEOUT_EN
    logic [3:0] beat_cnt;

    // limit marks the transfer that would be the MAX_BURST-th beat of this grant.
    assign limit = (beat_cnt == 4'(MAX_BURST - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt <= 4'd0;
        end else if (state == START) begin
            beat_cnt <= 4'd0;
        end else if (transfer) begin
            beat_cnt <= beat_cnt + 4'd1;
        end
    end
`else
    logic [3:0] unused_max_burst;

    assign unused_max_burst = 4'(MAX_BURST);
    assign limit            = 1'b0;
`endif

    always_comb begin
        state_next = state;
        rr_next    = rr_ptr;
        grant_next = grant_id;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_next = pick;
                    state_next = START;
                end
            end
            START: state_next = BURST;
            BURST: begin
                if (transfer && (own_last || limit)) begin
                    state_next = IDLE;
                    rr_next    = next_id(grant_id);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Restart pulse lines up with the START cycle; symbols trail their transfer by one edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr      <= 2'd0;
            grant_id    <= 2'd0;
            fsm_restart <= 1'b0;
            sym_valid   <= 1'b0;
            sym         <= 2'b00;
        end else begin
            rr_ptr      <= rr_next;
            grant_id    <= grant_next;
            fsm_restart <= (state == IDLE) && found;
            sym_valid   <= transfer;
            if (transfer) begin
                sym <= own_sym;
            end
        end
    end

endmodule

// File: tb/tb_fsm_input_arbiter.sv
// Self-checking bench for fsm_input_arbiter: directed vector table, corner sequences, and
// randomized traffic against a transaction-level reference model.
module tb_fsm_input_arbiter;

    localparam int MAX_BURST = 8;

`ifdef FSM_ARB_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic [2:0] req_valid;
    logic [5:0] req_sym;
    logic [2:0] req_last;
    logic [2:0] req_ready;
    logic       sym_valid;
    logic [1:0] sym;
    logic       fsm_restart;
    logic [1:0] grant_id;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    fsm_input_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_sym     (req_sym),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .sym_valid   (sym_valid),
        .sym         (sym),
        .fsm_restart (fsm_restart),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: owner = -1 when nobody holds the grant; fresh = restart cycle of a new grant.
    int m_owner, m_rr, m_beats, m_grant, m_src;
    bit m_fresh, m_sv, m_rs;
    int m_sym;

    task automatic model_reset();
        m_owner = -1; m_rr = 0; m_beats = 0; m_grant = 0; m_src = -1;
        m_fresh = 0; m_sv = 0; m_rs = 0; m_sym = 0;
    endtask

    task automatic model_update(input logic [2:0] v, input logic [5:0] s, input logic [2:0] l);
        m_sv  = 0;
        m_rs  = 0;
        m_src = -1;
        if (m_owner < 0) begin
            for (int k = 0; k < 3; k++) begin
                int id;
                id = (m_rr + k) % 3;
                if (m_owner < 0 && v[id]) begin
                    m_owner = id;
                    m_grant = id;
                    m_fresh = 1;
                    m_rs    = 1;
                end
            end
        end else if (m_fresh) begin
            m_fresh = 0;
            m_beats = 0;
        end else if (v[m_owner]) begin
            m_sv    = 1;
            m_src   = m_owner;
            m_sym   = int'(s[2*m_owner +: 2]);
            m_beats = m_beats + 1;
            if (l[m_owner] || (TIMEOUT && m_beats == MAX_BURST)) begin
                m_rr    = (m_owner + 1) % 3;
                m_owner = -1;
            end
        end
    endtask

    task automatic check(input string name, input int actual, input int want);
        checks++;
        if (actual != want) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, want, $time);
        end
    endtask

    task automatic compare_model(input string tag);
        int want_ready;
        want_ready = (m_owner >= 0 && !m_fresh) ? (1 << m_owner) : 0;
        check({tag, ".req_ready"},   int'(req_ready),   want_ready);
        check({tag, ".busy"},        int'(busy),        (m_owner >= 0) ? 1 : 0);
        check({tag, ".sym_valid"},   int'(sym_valid),   int'(m_sv));
        check({tag, ".sym"},         int'(sym),         m_sym);
        check({tag, ".fsm_restart"}, int'(fsm_restart), int'(m_rs));
        check({tag, ".grant_id"},    int'(grant_id),    m_grant);
        check({tag, ".exclusive"},   int'(fsm_restart & sym_valid), 0);
    endtask

    // One clock: drive at negedge, model the edge, sample at the next negedge.
    task automatic step(input string tag, input logic [2:0] v, input logic [5:0] s, input logic [2:0] l);
        req_valid = v;
        req_sym   = s;
        req_last  = l;
        @(posedge clk);
        model_update(v, s, l);
        @(negedge clk);
        compare_model(tag);
    endtask

    // Called at a negedge; asserts reset asynchronously and checks outputs right away.
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        check({tag, ".rst_ready"},   int'(req_ready),   0);
        check({tag, ".rst_sv"},      int'(sym_valid),   0);
        check({tag, ".rst_sym"},     int'(sym),         0);
        check({tag, ".rst_restart"}, int'(fsm_restart), 0);
        check({tag, ".rst_grant"},   int'(grant_id),    0);
        check({tag, ".rst_busy"},    int'(busy),        0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0] v;
        logic [5:0] s;
        logic [2:0] l;
        logic       e_sv;
        logic [1:0] e_sym;
        logic       e_rs;
        logic [1:0] e_grant;
        logic       e_busy;
        logic [2:0] e_ready;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int q_grant[$];
        int q_pulse[$];
        int exp_g[4];
        int cyc;
        int beats_left;
        int idx;
        int restarts;
        bit req1_pending;

        tbl[0] = '{3'b010, 6'b000100, 3'b000, 1'b0, 2'b00, 1'b1, 2'd1, 1'b1, 3'b000};
        tbl[1] = '{3'b010, 6'b000100, 3'b000, 1'b0, 2'b00, 1'b0, 2'd1, 1'b1, 3'b010};
        tbl[2] = '{3'b010, 6'b000100, 3'b000, 1'b1, 2'b01, 1'b0, 2'd1, 1'b1, 3'b010};
        tbl[3] = '{3'b010, 6'b001000, 3'b000, 1'b1, 2'b10, 1'b0, 2'd1, 1'b1, 3'b010};
        tbl[4] = '{3'b010, 6'b001100, 3'b010, 1'b1, 2'b11, 1'b0, 2'd1, 1'b0, 3'b000};
        tbl[5] = '{3'b000, 6'b000000, 3'b000, 1'b0, 2'b11, 1'b0, 2'd1, 1'b0, 3'b000};

        reset_n   = 1'b0;
        req_valid = 3'b000;
        req_sym   = 6'b0;
        req_last  = 3'b000;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        compare_model("init");

        // Three-beat burst from requester 1.
        for (int i = 0; i < 6; i++) begin
            string t;
            t = $sformatf("tbl%0d", i);
            step(t, tbl[i].v, tbl[i].s, tbl[i].l);
            check({t, ".sv"},      int'(sym_valid),   int'(tbl[i].e_sv));
            check({t, ".sym"},     int'(sym),         int'(tbl[i].e_sym));
            check({t, ".restart"}, int'(fsm_restart), int'(tbl[i].e_rs));
            check({t, ".grant"},   int'(grant_id),    int'(tbl[i].e_grant));
            check({t, ".busy"},    int'(busy),        int'(tbl[i].e_busy));
            check({t, ".ready"},   int'(req_ready),   int'(tbl[i].e_ready));
        end

        // All requesters, single-beat bursts: grants rotate with 2-cycle gaps.
        do_reset("rr");
        exp_g = '{0, 1, 2, 0};
        for (int i = 0; i < 12; i++) begin
            step("rr", 3'b111, 6'($urandom), 3'b111);
            if (fsm_restart) q_grant.push_back(int'(grant_id));
            if (sym_valid) q_pulse.push_back(i);
        end
        check("rr.grants", q_grant.size(), 4);
        for (int k = 0; k < 4 && k < q_grant.size(); k++)
            check($sformatf("rr.grant%0d", k), q_grant[k], exp_g[k]);
        check("rr.pulses", q_pulse.size(), 4);
        for (int k = 1; k < q_pulse.size(); k++)
            check($sformatf("rr.gap%0d", k), q_pulse[k] - q_pulse[k-1], 3);

        // Owner 2 stalls for 4 cycles while requester 0 waits.
        do_reset("stall");
        step("stall", 3'b100, 6'b010000, 3'b000);
        step("stall", 3'b100, 6'b010000, 3'b000);
        step("stall", 3'b100, 6'b010000, 3'b000);
        check("stall.beat1", int'(sym_valid), 1);
        for (int i = 0; i < 4; i++) begin
            step("stall", 3'b001, 6'b000011, 3'b001);
            check("stall.no_sv", int'(sym_valid), 0);
            check("stall.grant", int'(grant_id), 2);
            check("stall.ready", int'(req_ready), 3'b100);
        end
        step("stall", 3'b101, 6'b100011, 3'b101);
        check("stall.last_sv", int'(sym_valid), 1);
        check("stall.last_sym", int'(sym), 2);
        step("stall", 3'b001, 6'b000011, 3'b001);
        check("stall.regrant", int'(grant_id), 0);
        check("stall.restart", int'(fsm_restart), 1);
        step("stall", 3'b000, 6'b0, 3'b000);
        step("stall", 3'b000, 6'b0, 3'b000);

        // Requester 0 sends 12 beats while requester 1 waits for one beat.
        do_reset("long");
        q_grant.delete();
        beats_left   = 12;
        idx          = 0;
        restarts     = 0;
        req1_pending = 1;
        cyc          = 0;
        while (q_grant.size() < 13 && cyc < 100) begin
            logic [2:0] v;
            logic [2:0] l;
            v = {1'b0, req1_pending, beats_left > 0};
            l = {1'b0, 1'b1, beats_left == 1};
            step("long", v, {2'b00, 2'b11, 2'(idx)}, l);
            if (m_sv && m_src == 0) begin
                beats_left--;
                idx++;
            end
            if (m_sv && m_src == 1) req1_pending = 0;
            if (sym_valid) q_grant.push_back(int'(grant_id));
            if (fsm_restart) restarts++;
            cyc++;
        end
        check("long.beats", q_grant.size(), 13);
        for (int k = 0; k < q_grant.size() && k < 13; k++) begin
            int want;
            if (TIMEOUT) want = (k == MAX_BURST) ? 1 : 0;
            else         want = (k == 12) ? 1 : 0;
            check($sformatf("long.owner%0d", k), q_grant[k], want);
        end
        check("long.restarts", restarts, TIMEOUT ? 3 : 2);
        step("long", 3'b000, 6'b0, 3'b000);

        // Reset after the second beat of a burst.
        do_reset("mid");
        step("mid", 3'b010, 6'b000100, 3'b000);
        step("mid", 3'b010, 6'b000100, 3'b000);
        step("mid", 3'b010, 6'b000100, 3'b000);
        step("mid", 3'b010, 6'b001000, 3'b000);
        check("mid.beat2", int'(sym_valid), 1);
        do_reset("mid");
        step("mid", 3'b000, 6'b0, 3'b000);
        check("mid.no_sv", int'(sym_valid), 0);
        step("mid", 3'b111, 6'b111001, 3'b111);
        check("mid.first_grant", int'(grant_id), 0);
        check("mid.restart", int'(fsm_restart), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            logic [2:0] v;
            logic [2:0] l;
            v = 3'($urandom_range(0, 7));
            l = 3'b000;
            for (int b = 0; b < 3; b++) l[b] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) do_reset("rnd");
            step("rnd", v, 6'($urandom), l);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsm_input_arbiter.md
FSM_INPUT_ARBITER -- requirements
Module: fsm_input_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 8, range 2..15: maximum accepted beats per grant when FSM_ARB_TIMEOUT_EN is defined.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 req_valid  in  3  per-requester symbol valid, bit i = requester i.
REQ-005 req_sym  in  6  per-requester 2-bit symbol, bits [2i+1:2i] = requester i.
REQ-006 req_last  in  3  per-requester last-beat flag, qualified by req_valid.
REQ-007 req_ready  out  3  per-requester accept, combinational from state and grant.
REQ-008 sym_valid  out  1  registered: downstream symbol-FSM advance enable.
REQ-009 sym  out  2  registered symbol to downstream symbol-FSM input.
REQ-010 fsm_restart  out  1  registered one-cycle pulse: return downstream FSM to its initial state.
REQ-011 grant_id  out  2  registered id of current owner, 0..2; 3 never driven.
REQ-012 busy  out  1  high in START and BURST states.

Function
REQ-013 States: IDLE, START, BURST; encoded in 2 bits; unused encoding returns to IDLE next cycle.
REQ-014 IDLE: any req_valid high -> select first valid requester in round-robin order from rr_ptr (rr_ptr, rr_ptr+1, rr_ptr+2 mod 3); load grant_id; go START.
REQ-015 START: lasts exactly one cycle; fsm_restart=1; req_ready=0; beat counter cleared; go BURST.
REQ-016 BURST: req_ready[grant_id]=1, other bits 0; transfer = req_valid[grant_id] & req_ready[grant_id].
REQ-017 Each transfer: sym <= granted symbol, sym_valid <= 1 on next edge (1-cycle latency); no transfer -> sym_valid <= 0, sym holds.
REQ-018 Owner dropping req_valid mid-burst: stay in BURST, no beat counted, grant held.
REQ-019 Transfer with req_last=1 -> IDLE next cycle; rr_ptr <= grant_id+1 mod 3.
REQ-020 Non-granted requesters' req_valid/req_sym/req_last are ignored; symbols are never dropped or duplicated.
REQ-021 Minimum gap between two bursts: IDLE + START = 2 cycles without req_ready.
REQ-022 Downstream has no backpressure; every sym_valid pulse is consumed.
REQ-023 fsm_restart and sym_valid are never high in the same cycle.

Reset
REQ-024 reset_n low, asynchronously: state=IDLE, rr_ptr=0, grant_id=0, beat counter=0, sym_valid=0, sym=2'b00, fsm_restart=0, busy=0, req_ready=0.
REQ-025 Reset mid-burst: in-flight burst abandoned, no sym_valid after deassertion until a new START; first arbitration after reset starts at requester 0.

Configuration
REQ-026 FSM_ARB_TIMEOUT_EN defined: 4-bit beat counter counts transfers in BURST; the MAX_BURST-th transfer without req_last -> IDLE, rr_ptr <= grant_id+1 mod 3; the requester re-arbitrates for the remainder and gets a fresh fsm_restart.
REQ-027 FSM_ARB_TIMEOUT_EN undefined: no beat counter; grant held until a req_last transfer; MAX_BURST has no effect.

Verification
REQ-028 Reset then req_valid=3'b010, 3 beats sym 01,10,11 with last on 3rd -> grant_id=1, fsm_restart pulse, then sym_valid 3 cycles with sym 01,10,11, busy low 1 cycle after final transfer.
REQ-029 req_valid=3'b111 held, single-beat bursts (last=1) -> grants in order 0,1,2,0; 2-cycle gaps between transfers.
REQ-030 Owner 2 drops valid for 4 cycles mid-burst while requester 0 valid -> grant stays 2, no sym_valid for 4 cycles, requester 0 served only after owner's last.
REQ-031 FSM_ARB_TIMEOUT_EN, MAX_BURST=8, requester 0 sends 12 beats, requester 1 valid -> 8 beats from 0, grant to 1, then 0 resumes with new fsm_restart and remaining 4 beats; without macro all 12 beats contiguous.
REQ-032 reset_n low for 1 cycle after 2nd beat of a burst -> all outputs at reset values immediately; after release, requester 0 granted first when all valid.
